// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : RISC-V MEM stage: req/ack data-memory access, lane alignment,
//            load extension, timeout abort and the MEM/WB pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validm,
  input  logic        regWrtm,
  input  logic        memWrtm,
  input  logic [1:0]  rsltSrcm,
  input  logic [2:0]  funct3m,
  input  logic [4:0]  rdm,
  input  logic [31:0] aluRsltm,
  input  logic [31:0] wrtDm,
  input  logic [31:0] pc4m,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        stallm,
  output logic        misalignm,
  output logic        busErrm,
  output logic        validw,
  output logic        regWrtw,
  output logic [1:0]  rsltSrcw,
  output logic [4:0]  rdw,
  output logic [31:0] aluRsltw,
  output logic [31:0] rdDw,
  output logic [31:0] pc4w
);

  localparam int c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;

  logic        r_validw;
  logic        r_regWrtw;
  logic [1:0]  r_rsltSrcw;
  logic [4:0]  r_rdw;
  logic [31:0] r_aluRsltw;
  logic [31:0] r_rdDw;
  logic [31:0] r_pc4w;

  logic        w_memop;
  logic        w_load;
  logic        w_mis;
  logic        w_req;
  logic        w_abort;
  logic        w_bubble;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rdext;

  assign w_memop = validm & (memWrtm | (rsltSrcm == 2'b01));
  assign w_load  = (rsltSrcm == 2'b01) & ~memWrtm;

  // Lane steering; unlisted size codes fall through to word accesses
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wrtDm;
    w_mis   = 1'b0;
    case (funct3m)
      3'b000, 3'b100: begin
        w_be    = 4'b0001 << aluRsltm[1:0];
        w_wdata = {4{wrtDm[7:0]}};
      end
      3'b001, 3'b101: begin
        w_be    = 4'b0011 << aluRsltm[1:0];
        w_wdata = {2{wrtDm[15:0]}};
        w_mis   = aluRsltm[0];
      end
      default: w_mis = |aluRsltm[1:0];
    endcase
  end

  always_comb begin
    w_byte = memRdata[7:0];
    case (aluRsltm[1:0])
      2'b01:   w_byte = memRdata[15:8];
      2'b10:   w_byte = memRdata[23:16];
      2'b11:   w_byte = memRdata[31:24];
      default: w_byte = memRdata[7:0];
    endcase
    w_half = aluRsltm[1] ? memRdata[31:16] : memRdata[15:0];
    case (funct3m)
      3'b000:  w_rdext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_rdext = {24'd0, w_byte};
      3'b001:  w_rdext = {{16{w_half[15]}}, w_half};
      3'b101:  w_rdext = {16'd0, w_half};
      default: w_rdext = memRdata;
    endcase
  end

  assign w_req   = w_memop & ~w_mis & ~rst;
  assign w_abort = w_req & (r_state == S_WAIT) & ~memAck & (r_cnt == c_cnt_last);

  assign memReq    = w_req;
  assign memWe     = w_req & memWrtm;
  assign memAddr   = {aluRsltm[31:2], 2'b00};
  assign memWdata  = w_wdata;
  assign memBe     = w_be;
  assign stallm    = w_req & ~memAck & ~w_abort;
  assign misalignm = w_memop & w_mis & ~rst;
  assign busErrm   = w_abort;

  assign w_bubble = stallm | misalignm | busErrm;

  // Any cycle that ends without an outstanding request returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (!w_req || memAck || w_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      r_state <= S_WAIT;
      r_cnt   <= c_cnt_w'(1);
    end else begin
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_validw   <= 1'b0;
      r_regWrtw  <= 1'b0;
      r_rsltSrcw <= 2'b00;
      r_rdw      <= 5'd0;
      r_aluRsltw <= 32'd0;
      r_rdDw     <= 32'd0;
      r_pc4w     <= 32'd0;
    end else if (w_bubble) begin
      r_validw   <= 1'b0;
      r_regWrtw  <= 1'b0;
      r_rsltSrcw <= 2'b00;
      r_rdw      <= 5'd0;
      r_aluRsltw <= 32'd0;
      r_rdDw     <= 32'd0;
      r_pc4w     <= 32'd0;
    end else begin
      r_validw   <= validm;
      r_regWrtw  <= validm & regWrtm;
      r_rsltSrcw <= rsltSrcm;
      r_rdw      <= rdm;
      r_aluRsltw <= aluRsltm;
      r_rdDw     <= (w_memop & w_load) ? w_rdext : 32'd0;
      r_pc4w     <= pc4m;
    end
  end

  assign validw   = r_validw;
  assign regWrtw  = r_regWrtw;
  assign rsltSrcw = r_rsltSrcw;
  assign rdw      = r_rdw;
  assign aluRsltw = r_aluRsltw;
  assign rdDw     = r_rdDw;
  assign pc4w     = r_pc4w;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        validm, regWrtm, memWrtm;
  logic [1:0]  rsltSrcm;
  logic [2:0]  funct3m;
  logic [4:0]  rdm;
  logic [31:0] aluRsltm, wrtDm, pc4m;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic [31:0] memRdata;
  logic        memAck;
  logic        stallm, misalignm, busErrm;
  logic        validw, regWrtw;
  logic [1:0]  rsltSrcw;
  logic [4:0]  rdw;
  logic [31:0] aluRsltw, rdDw, pc4w;

  int errors = 0;
  int checks = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .validm(validm), .regWrtm(regWrtm), .memWrtm(memWrtm),
    .rsltSrcm(rsltSrcm), .funct3m(funct3m), .rdm(rdm),
    .aluRsltm(aluRsltm), .wrtDm(wrtDm), .pc4m(pc4m),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memBe(memBe),
    .memRdata(memRdata), .memAck(memAck),
    .stallm(stallm), .misalignm(misalignm), .busErrm(busErrm),
    .validw(validw), .regWrtw(regWrtw), .rsltSrcw(rsltSrcw),
    .rdw(rdw), .aluRsltw(aluRsltw), .rdDw(rdDw), .pc4w(pc4w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic v, input logic rw, input logic mw, input logic [1:0] src,
                    input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                    input logic [31:0] wd);
    validm   = v;
    regWrtm  = rw;
    memWrtm  = mw;
    rsltSrcm = src;
    funct3m  = f3;
    rdm      = rd;
    aluRsltm = addr;
    wrtDm    = wd;
    pc4m     = addr + 32'd4;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    op(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0);
    memAck   = 1'b0;
    memRdata = 32'd0;
    #3;
    chk("reset_memReq", {31'd0, memReq}, 32'd0);
    chk("reset_validw", {31'd0, validw}, 32'd0);
    chk("reset_rdDw", rdDw, 32'd0);
    chk("reset_busErr", {31'd0, busErrm}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // lw 0x100, zero-wait
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd5, 32'h100, 32'd0);
    memAck = 1'b1; memRdata = 32'hDEADBEEF;
    #1;
    chk("lw_req", {31'd0, memReq}, 32'd1);
    chk("lw_stall", {31'd0, stallm}, 32'd0);
    chk("lw_be", {28'd0, memBe}, 32'hF);
    chk("lw_we", {31'd0, memWe}, 32'd0);
    next_cycle();
    chk("lw_validw", {31'd0, validw}, 32'd1);
    chk("lw_regWrtw", {31'd0, regWrtw}, 32'd1);
    chk("lw_rdDw", rdDw, 32'hDEADBEEF);
    chk("lw_rsltSrcw", {30'd0, rsltSrcw}, 32'd1);
    chk("lw_rdw", {27'd0, rdw}, 32'd5);
    chk("lw_pc4w", pc4w, 32'h104);

    // lb / lbu at 0x103
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b01, 3'b000, 5'd6, 32'h103, 32'd0);
    memRdata = 32'h80112233;
    #1;
    chk("lb_be", {28'd0, memBe}, 32'h8);
    next_cycle();
    chk("lb_rdDw", rdDw, 32'hFFFFFF80);
    @(negedge clk);
    funct3m = 3'b100;
    next_cycle();
    chk("lbu_rdDw", rdDw, 32'h00000080);

    // lh / lhu at 0x102
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b01, 3'b001, 5'd7, 32'h102, 32'd0);
    memRdata = 32'h80015555;
    next_cycle();
    chk("lh_rdDw", rdDw, 32'hFFFF8001);
    @(negedge clk);
    funct3m = 3'b101;
    next_cycle();
    chk("lhu_rdDw", rdDw, 32'h00008001);

    // sb at 0x201
    @(negedge clk);
    op(1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h201, 32'h000000EE);
    #1;
    chk("sb_be", {28'd0, memBe}, 32'h2);
    chk("sb_wdata", memWdata, 32'hEEEEEEEE);
    chk("sb_we", {31'd0, memWe}, 32'd1);
    next_cycle();
    chk("sb_rdDw", rdDw, 32'd0);

    // sh at 0x202, ack in third request cycle
    @(negedge clk);
    op(1'b1, 1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h202, 32'h0000ABCD);
    memAck = 1'b0;
    #1;
    chk("sh_c1_stall", {31'd0, stallm}, 32'd1);
    chk("sh_be", {28'd0, memBe}, 32'hC);
    chk("sh_wdata", memWdata, 32'hABCDABCD);
    chk("sh_addr", memAddr, 32'h200);
    next_cycle();
    chk("sh_c1_bubble", {31'd0, validw}, 32'd0);
    @(negedge clk);
    chk("sh_c2_stall", {31'd0, stallm}, 32'd1);
    chk("sh_c2_req", {31'd0, memReq}, 32'd1);
    chk("sh_c2_be", {28'd0, memBe}, 32'hC);
    next_cycle();
    @(negedge clk);
    memAck = 1'b1;
    #1;
    chk("sh_c3_stall", {31'd0, stallm}, 32'd0);
    chk("sh_c3_addr", memAddr, 32'h200);
    next_cycle();
    chk("sh_validw", {31'd0, validw}, 32'd1);
    chk("sh_regWrtw", {31'd0, regWrtw}, 32'd0);

    // misaligned lw at 0x101
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd8, 32'h101, 32'd0);
    #1;
    chk("mis_pulse", {31'd0, misalignm}, 32'd1);
    chk("mis_req", {31'd0, memReq}, 32'd0);
    chk("mis_stall", {31'd0, stallm}, 32'd0);
    next_cycle();
    chk("mis_validw", {31'd0, validw}, 32'd0);
    chk("mis_regWrtw", {31'd0, regWrtw}, 32'd0);

    // timeout: no ack for 4 request cycles
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h100, 32'd0);
    memAck = 1'b0;
    #1;
    chk("to_c1_stall", {31'd0, stallm}, 32'd1);
    chk("to_c1_berr", {31'd0, busErrm}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("to_c2_stall", {31'd0, stallm}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("to_c3_stall", {31'd0, stallm}, 32'd1);
    chk("to_c3_berr", {31'd0, busErrm}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("to_c4_req", {31'd0, memReq}, 32'd1);
    chk("to_c4_stall", {31'd0, stallm}, 32'd0);
    chk("to_c4_berr", {31'd0, busErrm}, 32'd1);
    next_cycle();
    chk("to_validw", {31'd0, validw}, 32'd0);

    // ALU pass-through after abort
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd7, 32'h1234, 32'd0);
    #1;
    chk("alu_req", {31'd0, memReq}, 32'd0);
    next_cycle();
    chk("alu_validw", {31'd0, validw}, 32'd1);
    chk("alu_rslt", aluRsltw, 32'h1234);
    chk("alu_rdDw", rdDw, 32'd0);

    // ack in the timeout cycle wins
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd10, 32'h100, 32'd0);
    memAck = 1'b0; memRdata = 32'h12345678;
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    memAck = 1'b1;
    #1;
    chk("tack_stall", {31'd0, stallm}, 32'd0);
    chk("tack_berr", {31'd0, busErrm}, 32'd0);
    next_cycle();
    chk("tack_validw", {31'd0, validw}, 32'd1);
    chk("tack_rdDw", rdDw, 32'h12345678);

    // reset while waiting
    @(negedge clk);
    op(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd11, 32'h100, 32'd0);
    memAck = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rstw_req_before", {31'd0, memReq}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_req", {31'd0, memReq}, 32'd0);
    chk("rstw_validw", {31'd0, validw}, 32'd0);
    chk("rstw_rdw", {27'd0, rdw}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    memAck = 1'b1; memRdata = 32'hDEADBEEF;
    #1;
    chk("post_rst_stall", {31'd0, stallm}, 32'd0);
    next_cycle();
    chk("post_rst_validw", {31'd0, validw}, 32'd1);
    chk("post_rst_rdDw", rdDw, 32'hDEADBEEF);
    chk("post_rst_rdw", {27'd0, rdw}, 32'd11);

    @(negedge clk);
    validm = 1'b0;
    memAck = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
